// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pkg
//  Description : Shared types and constants for the instruction assembler
//                and the downstream instruction register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    // Bytes per frame: one opcode, four address bytes, four data bytes
    localparam int FRAME_LEN = 9;

    // Bytes per multi-byte field, and the byte index of the last one
    localparam int       FIELD_BYTES    = (FRAME_LEN - 1) / 2;
    localparam logic [1:0] LAST_FIELD_IDX = 2'(FIELD_BYTES - 1);

    // Assembled instruction, packed as {address, data, opcode}
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [7:0]  opcode;
    } instruction_word_t;

    // Frame parser states
    typedef enum logic [1:0] {
        S_OPC  = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_shift8.sv
`default_nettype none
// ============================================================================
//  Module      : instr_shift8
//  Description : 32-bit shift register taking one byte per enabled cycle,
//                MSB byte first. word_o shows the value the register holds
//                after the current edge, so a field completed on this edge
//                can be captured downstream on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_shift8 (
    input  logic        clock,
    input  logic        resetN,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [31:0] shift_q;
    logic [31:0] shift_d;

    // Next value: clear wins over shift, otherwise hold
    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {shift_q[23:0], byte_i};
        end
    end

    // Shift register with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign word_o = shift_d;

endmodule
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : instr_assembler
//  Description : Assembles 9-byte serial frames (opcode, address MSB first,
//                data MSB first) into a 72-bit instruction word with a
//                valid/ready output handshake and a framing error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler
    import instr_pkg::*;
#(
    parameter logic [7:0] ILLEGAL_OPCODE = 8'hFF,
    parameter int         CNT_W          = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [7:0]        in_byte,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output instruction_word_t out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_frame,
    output logic [CNT_W-1:0]  frame_count
);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        opc_q, opc_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    instruction_word_t word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              handshake;
    logic              shift_clr;
    logic              addr_en;
    logic              data_en;
    logic              load_word;
    logic [31:0]       addr_word;
    logic [31:0]       data_word;

    // A full word that downstream has not taken blocks further input
    assign in_ready  = !(valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = valid_q && out_ready;

    instr_shift8 u_addr (
        .clock  (clock),
        .resetN (resetN),
        .clr_i  (shift_clr),
        .en_i   (addr_en),
        .byte_i (in_byte),
        .word_o (addr_word)
    );

    instr_shift8 u_data (
        .clock  (clock),
        .resetN (resetN),
        .clr_i  (shift_clr),
        .en_i   (data_en),
        .byte_i (in_byte),
        .word_o (data_word)
    );

    // Frame parser: sof always restarts, illegal opcodes and stray bytes flag errors
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opc_d     = opc_q;
        err_d     = 1'b0;
        shift_clr = 1'b0;
        addr_en   = 1'b0;
        data_en   = 1'b0;
        load_word = 1'b0;
        if (accept) begin
            if (in_sof) begin
                // A sof outside S_OPC aborts a partial frame; one pulse covers
                // the abort and an illegal opcode arriving together
                err_d = (state_q != S_OPC) || (in_byte == ILLEGAL_OPCODE);
                idx_d = 2'd0;
                if (in_byte == ILLEGAL_OPCODE) begin
                    state_d = S_OPC;
                end else begin
                    opc_d     = in_byte;
                    state_d   = S_ADDR;
                    shift_clr = 1'b1;
                end
            end else begin
                case (state_q)
                    S_ADDR: begin
                        addr_en = 1'b1;
                        if (idx_q == LAST_FIELD_IDX) begin
                            state_d = S_DATA;
                            idx_d   = 2'd0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    S_DATA: begin
                        data_en = 1'b1;
                        if (idx_q == LAST_FIELD_IDX) begin
                            load_word = 1'b1;
                            state_d   = S_OPC;
                            idx_d     = 2'd0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Output stage: a new word overrides the clear from a same-cycle handshake
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (handshake) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (load_word) begin
            valid_d        = 1'b1;
            word_d.address = addr_word;
            word_d.data    = data_word;
            word_d.opcode  = opc_q;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_OPC;
            idx_q   <= 2'd0;
            opc_q   <= 8'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opc_q   <= opc_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_word    = word_q;
    assign out_valid   = valid_q;
    assign err_frame   = err_q;
    assign frame_count = cnt_q;

endmodule
`default_nettype wire
